// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: MEM-stage request/response and data_ram port bundle
// for mem_access_ctrl. "master" is the environment side: the MEM stage plus
// data_ram read data. "slave" is the controller side.
interface mem_access_ctrl_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              req_valid;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              stall_req;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              misalign_err;
   logic              ram_ce;
   logic              ram_we;
   logic              ram_re;
   logic [1:0]        ram_wvalid_bit;
   logic [1:0]        ram_rvalid_bit;
   logic [ADDR_W-1:0] ram_waddr;
   logic [ADDR_W-1:0] ram_raddr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  stall_req, resp_valid, resp_rdata, misalign_err,
      input  ram_ce, ram_we, ram_re, ram_wvalid_bit, ram_rvalid_bit,
      input  ram_waddr, ram_raddr, ram_wdata,
      output ram_rdata
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output stall_req, resp_valid, resp_rdata, misalign_err,
      output ram_ce, ram_we, ram_re, ram_wvalid_bit, ram_rvalid_bit,
      output ram_waddr, ram_raddr, ram_wdata,
      input  ram_rdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store access controller between the MEM stage and
// data_ram.
//
// Aligned accesses pass straight through to the RAM in the same cycle.
// When MEM_MISALIGN_SPLIT_EN is defined, misaligned half/word accesses are
// split into sequential byte accesses while MEM is stalled. When it is
// undefined, a misaligned request makes no RAM access and instead gets a
// one-cycle misalign_err response.
//
// Load data is sign- or zero-extended before it is returned.
module mem_access_ctrl #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   mem_access_ctrl_if.slave bus
);

   localparam logic [1:0] VB_BYTE = 2'd0;
   localparam logic [1:0] VB_HALF = 2'd1;
   localparam logic [1:0] VB_WORD = 2'd2;
   localparam logic [1:0] VB_NONE = 2'd3;

`ifdef MEM_MISALIGN_SPLIT_EN
   typedef enum logic {IDLE, SPLIT} state_t;
`else
   typedef enum logic {IDLE} state_t;
`endif

   state_t state_q, state_d;

`ifdef MEM_MISALIGN_SPLIT_EN
   logic [1:0]        idx_q, idx_d;
   logic [31:0]       buf_q, buf_d;
   logic              cap_load;
   logic              cap_we_q;
   logic              cap_uns_q;
   logic [1:0]        cap_size_q;
   logic [ADDR_W-1:0] cap_addr_q;
   logic [31:0]       cap_wdata_q;
   logic [ADDR_W-1:0] split_addr;
   logic [31:0]       asm_data;
   logic              split_last;
`endif

   function automatic logic [31:0] extend(input logic [1:0] size, input logic uns,
                                          input logic [31:0] data);
      logic [31:0] r;
      case (size)
         VB_BYTE: r = {{24{data[7] & ~uns}}, data[7:0]};
         VB_HALF: r = {{16{data[15] & ~uns}}, data[15:0]};
         default: r = data;
      endcase
      return r;
   endfunction

   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lsb);
      logic r;
      case (size)
         VB_HALF: r = ~lsb[0];
         VB_WORD: r = (lsb == 2'b00);
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   // State register plus the captured context of a split sequence
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
`ifdef MEM_MISALIGN_SPLIT_EN
         idx_q       <= '0;
         buf_q       <= '0;
         cap_we_q    <= 1'b0;
         cap_uns_q   <= 1'b0;
         cap_size_q  <= '0;
         cap_addr_q  <= '0;
         cap_wdata_q <= '0;
`endif
      end else begin
         state_q <= state_d;
`ifdef MEM_MISALIGN_SPLIT_EN
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         if (cap_load) begin
            cap_we_q    <= bus.req_we;
            cap_uns_q   <= bus.req_unsigned;
            cap_size_q  <= bus.req_size;
            cap_addr_q  <= bus.req_addr;
            cap_wdata_q <= bus.req_wdata;
         end
`endif
      end
   end

   // Next-state, RAM port drive and MEM response; everything is held idle during reset
   always_comb begin
      state_d             = state_q;
      bus.stall_req       = 1'b0;
      bus.resp_valid      = 1'b0;
      bus.resp_rdata      = '0;
      bus.misalign_err    = 1'b0;
      bus.ram_ce          = ~rst;
      bus.ram_we          = 1'b0;
      bus.ram_re          = 1'b0;
      bus.ram_wvalid_bit  = VB_BYTE;
      bus.ram_rvalid_bit  = VB_BYTE;
      bus.ram_waddr       = '0;
      bus.ram_raddr       = '0;
      bus.ram_wdata       = '0;
`ifdef MEM_MISALIGN_SPLIT_EN
      idx_d      = idx_q;
      buf_d      = buf_q;
      cap_load   = 1'b0;
      split_addr = cap_addr_q + ADDR_W'(idx_q);
      split_last = (cap_size_q == VB_HALF) ? (idx_q == 2'd1) : (idx_q == 2'd3);
      // buf holds the bytes already read; the current byte is merged in here
      asm_data   = buf_q;
      asm_data[{idx_q, 3'b000} +: 8] = bus.ram_rdata[7:0];
`endif
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid && bus.req_size != VB_NONE) begin
                  if (is_aligned(bus.req_size, bus.req_addr[1:0])) begin
                     bus.resp_valid = 1'b1;
                     if (bus.req_we) begin
                        bus.ram_we         = 1'b1;
                        bus.ram_wvalid_bit = bus.req_size;
                        bus.ram_waddr      = bus.req_addr;
                        bus.ram_wdata      = bus.req_wdata;
                     end else begin
                        bus.ram_re         = 1'b1;
                        bus.ram_rvalid_bit = bus.req_size;
                        bus.ram_raddr      = bus.req_addr;
                        bus.resp_rdata     = extend(bus.req_size, bus.req_unsigned,
                                                    bus.ram_rdata);
                     end
                  end else begin
`ifdef MEM_MISALIGN_SPLIT_EN
                     // Byte 0 goes out straight from the live request in this cycle
                     if (bus.req_we) begin
                        bus.ram_we    = 1'b1;
                        bus.ram_waddr = bus.req_addr;
                        bus.ram_wdata = {24'h0, bus.req_wdata[7:0]};
                     end else begin
                        bus.ram_re    = 1'b1;
                        bus.ram_raddr = bus.req_addr;
                        buf_d         = {buf_q[31:8], bus.ram_rdata[7:0]};
                     end
                     cap_load      = 1'b1;
                     idx_d         = 2'd1;
                     state_d       = SPLIT;
                     bus.stall_req = 1'b1;
`else
                     bus.misalign_err = 1'b1;
                     bus.resp_valid   = 1'b1;
`endif
                  end
               end
            end
`ifdef MEM_MISALIGN_SPLIT_EN
            SPLIT: begin
               if (cap_we_q) begin
                  bus.ram_we    = 1'b1;
                  bus.ram_waddr = split_addr;
                  bus.ram_wdata = {24'h0, cap_wdata_q[{idx_q, 3'b000} +: 8]};
               end else begin
                  bus.ram_re    = 1'b1;
                  bus.ram_raddr = split_addr;
                  buf_d         = asm_data;
               end
               if (split_last) begin
                  bus.resp_valid = 1'b1;
                  bus.resp_rdata = cap_we_q ? 32'h0 : extend(cap_size_q, cap_uns_q, asm_data);
                  idx_d          = '0;
                  state_d        = IDLE;
               end else begin
                  bus.stall_req = 1'b1;
                  idx_d         = idx_q + 2'd1;
               end
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized load/store traffic against a byte-array
// reference memory. The bench also holds a behavioural data_ram model that
// stands in for the real RAM. Timing expectations follow MEM_MISALIGN_SPLIT_EN.
module tb_mem_access_ctrl;

   localparam int unsigned ADDR_W = 8;

   logic clk;
   logic rst;

   mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_mis = 0;

   logic [7:0] mem  [256] = '{default: 8'h00};
   logic [7:0] smem [256] = '{default: 8'h00};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // data_ram stand-in: combinational read of little-endian bytes
   always_comb begin
      bus.ram_rdata = 32'h0;
      if (bus.ram_re) begin
         case (bus.ram_rvalid_bit)
            2'd0:    bus.ram_rdata = {24'h0, mem[bus.ram_raddr]};
            2'd1:    bus.ram_rdata = {16'h0, mem[bus.ram_raddr + 8'd1], mem[bus.ram_raddr]};
            default: bus.ram_rdata = {mem[bus.ram_raddr + 8'd3], mem[bus.ram_raddr + 8'd2],
                                      mem[bus.ram_raddr + 8'd1], mem[bus.ram_raddr]};
         endcase
      end
   end

   // data_ram stand-in: clocked byte writes
   always @(posedge clk) begin
      if (bus.ram_we) begin
         mem[bus.ram_waddr] <= bus.ram_wdata[7:0];
         if (bus.ram_wvalid_bit != 2'd0)
            mem[bus.ram_waddr + 8'd1] <= bus.ram_wdata[15:8];
         if (bus.ram_wvalid_bit == 2'd2) begin
            mem[bus.ram_waddr + 8'd2] <= bus.ram_wdata[23:16];
            mem[bus.ram_waddr + 8'd3] <= bus.ram_wdata[31:24];
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                              input logic [7:0] addr);
      longint unsigned v;
      int unsigned n;
      n = 1 << size;
      v = 0;
      for (int unsigned i = 0; i < n; i++)
         v = v | (longint'(smem[(int'(addr) + i) % 256]) << (8 * i));
      if (!uns && (((v >> (8 * n - 1)) & 1) == 1))
         v = v | (64'hFFFF_FFFF << (8 * n));
      return 32'(v);
   endfunction

   task automatic model_store(input logic [1:0] size, input logic [7:0] addr,
                              input logic [31:0] wdata);
      int unsigned n;
      n = 1 << size;
      for (int unsigned i = 0; i < n; i++)
         smem[(int'(addr) + i) % 256] = 8'(wdata >> (8 * i));
   endtask

   // One MEM request, run to its response and compared with the reference model
   task automatic xfer(input logic we, input logic [1:0] size, input logic uns,
                       input logic [7:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd);
      int unsigned n, exp_cyc, exp_acc, cyc, stalls, wr, rdn, both, errs;
      logic aligned, exp_err, done;
      logic [31:0] exp_rd;
      n       = 1 << size;
      aligned = (size == 2'd0) || (size == 2'd1 && !addr[0]) ||
                (size == 2'd2 && addr[1:0] == 2'b00);
`ifdef MEM_MISALIGN_SPLIT_EN
      exp_cyc = aligned ? 1 : n;
      exp_acc = aligned ? 1 : n;
      exp_err = 1'b0;
`else
      exp_cyc = 1;
      exp_acc = aligned ? 1 : 0;
      exp_err = !aligned;
`endif
      exp_rd = (!we && exp_acc != 0) ? model_load(size, uns, addr) : 32'h0;

      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      cyc = 0; stalls = 0; wr = 0; rdn = 0; both = 0; errs = 0;
      done = 1'b0;
      rd = 32'h0;
      while (!done && cyc < 12) begin
         @(negedge clk);
         cyc++;
         if (bus.stall_req)             stalls++;
         if (bus.ram_we)                wr++;
         if (bus.ram_re)                rdn++;
         if (bus.ram_we && bus.ram_re)  both++;
         if (bus.misalign_err)          errs++;
         if (bus.resp_valid) begin
            done = 1'b1;
            rd   = bus.resp_rdata;
         end
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      if (we && exp_acc != 0) model_store(size, addr, wdata);

      check_eq("resp_seen",    {31'h0, done}, 32'h1);
      check_eq("cycles",       cyc,    exp_cyc);
      check_eq("stall_cycles", stalls, exp_cyc - 1);
      check_eq("ram_writes",   wr,     we ? exp_acc : 0);
      check_eq("ram_reads",    rdn,    we ? 0 : exp_acc);
      check_eq("we_re_same",   both,   0);
      check_eq("misalign_err", errs,   {31'h0, exp_err});
      check_eq("resp_rdata",   rd,     exp_rd);
   endtask

   logic [31:0] rd;
   int unsigned diffs;

   initial begin
      rst              = 1'b1;
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;
      #3;
      check_eq("rst_stall",   {31'h0, bus.stall_req},    32'h0);
      check_eq("rst_resp",    {31'h0, bus.resp_valid},   32'h0);
      check_eq("rst_rdata",   bus.resp_rdata,            32'h0);
      check_eq("rst_err",     {31'h0, bus.misalign_err}, 32'h0);
      check_eq("rst_ce",      {31'h0, bus.ram_ce},       32'h0);
      check_eq("rst_addr",    {16'h0, bus.ram_waddr, bus.ram_raddr}, 32'h0);
      check_eq("rst_wdata",   bus.ram_wdata,             32'h0);
      // a request presented during reset must not reach the RAM
      bus.req_valid = 1'b1;
      bus.req_size  = 2'd2;
      bus.req_addr  = 8'h10;
      #1;
      check_eq("rst_req_blocked", {30'h0, bus.ram_we, bus.ram_re}, 32'h0);
      check_eq("rst_req_noresp",  {31'h0, bus.resp_valid}, 32'h0);
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("ce_after_rst", {31'h0, bus.ram_ce}, 32'h1);
      @(posedge clk);
      #1;

      // aligned accesses and extension
      xfer(1'b1, 2'd2, 1'b0, 8'h10, 32'h1122_3344, rd);
      xfer(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, rd);
      check_eq("lw_aligned", rd, 32'h1122_3344);
      xfer(1'b1, 2'd1, 1'b0, 8'h12, 32'h0000_8001, rd);
      xfer(1'b0, 2'd1, 1'b0, 8'h12, 32'h0, rd);
      check_eq("lh_signed", rd, 32'hFFFF_8001);
      xfer(1'b0, 2'd0, 1'b0, 8'h13, 32'h0, rd);
      check_eq("lb_signed", rd, 32'hFFFF_FF80);
      xfer(1'b0, 2'd0, 1'b1, 8'h13, 32'h0, rd);
      check_eq("lbu", rd, 32'h0000_0080);
      xfer(1'b0, 2'd1, 1'b1, 8'h12, 32'h0, rd);
      check_eq("lhu", rd, 32'h0000_8001);

      // reserved size: no access, no response
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = 2'd3;
      bus.req_addr  = 8'h30;
      @(negedge clk);
      check_eq("size3_noresp", {31'h0, bus.resp_valid}, 32'h0);
      check_eq("size3_noacc",  {29'h0, bus.stall_req, bus.ram_we, bus.ram_re}, 32'h0);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;

`ifdef MEM_MISALIGN_SPLIT_EN
      xfer(1'b1, 2'd2, 1'b0, 8'h21, 32'hAABB_CCDD, rd);
      for (int unsigned i = 0; i < 4; i++) begin
         xfer(1'b0, 2'd0, 1'b1, 8'(8'h21 + i), 32'h0, rd);
         check_eq("split_sw_byte", rd, (32'hAABB_CCDD >> (8 * i)) & 32'hFF);
      end
      xfer(1'b1, 2'd0, 1'b0, 8'h23, 32'h34, rd);
      xfer(1'b1, 2'd0, 1'b0, 8'h24, 32'h12, rd);
      xfer(1'b0, 2'd1, 1'b1, 8'h23, 32'h0, rd);
      check_eq("split_lhu", rd, 32'h0000_1234);
      xfer(1'b1, 2'd0, 1'b0, 8'h24, 32'hF2, rd);
      xfer(1'b0, 2'd1, 1'b0, 8'h23, 32'h0, rd);
      check_eq("split_lh", rd, 32'hFFFF_F234);
      // word at the top of the address space wraps to 0
      xfer(1'b1, 2'd2, 1'b0, 8'hFF, 32'hCAFE_F00D, rd);
      xfer(1'b0, 2'd2, 1'b0, 8'hFF, 32'h0, rd);
      check_eq("wrap_lw", rd, 32'hCAFE_F00D);
      xfer(1'b0, 2'd0, 1'b1, 8'h00, 32'h0, rd);
      check_eq("wrap_byte0", rd, 32'h0000_00F0);

      // reset in the second cycle of a split store
      xfer(1'b1, 2'd2, 1'b0, 8'h40, 32'h0, rd);
      bus.req_valid    = 1'b1;
      bus.req_we       = 1'b1;
      bus.req_size     = 2'd2;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 8'h41;
      bus.req_wdata    = 32'h5566_7788;
      @(negedge clk);
      check_eq("pre_rst_stall", {31'h0, bus.stall_req}, 32'h1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_eq("mid_rst_stall", {31'h0, bus.stall_req}, 32'h0);
      check_eq("mid_rst_idle",  {29'h0, bus.resp_valid, bus.ram_we, bus.ram_re}, 32'h0);
      smem[8'h41] = 8'h88;
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      xfer(1'b0, 2'd2, 1'b0, 8'h40, 32'h0, rd);
      check_eq("rst_only_byte0", rd, 32'h0000_8800);
`else
      xfer(1'b1, 2'd2, 1'b0, 8'h20, 32'h0102_0304, rd);
      xfer(1'b0, 2'd2, 1'b0, 8'h22, 32'h0, rd);
      check_eq("misalign_rdata", rd, 32'h0);
      xfer(1'b1, 2'd1, 1'b0, 8'h21, 32'hFFFF, rd);
      xfer(1'b0, 2'd2, 1'b0, 8'h20, 32'h0, rd);
      check_eq("misalign_no_write", rd, 32'h0102_0304);
      xfer(1'b1, 2'd2, 1'b0, 8'hFC, 32'hCAFE_F00D, rd);
      xfer(1'b0, 2'd2, 1'b0, 8'hFC, 32'h0, rd);
      check_eq("top_lw", rd, 32'hCAFE_F00D);
`endif

      // randomized back-to-back traffic
      for (int i = 0; i < 300; i++) begin
         logic [7:0] a;
         if ($urandom_range(0, 3) == 0) a = 8'(8'hFC + $urandom_range(0, 3));
         else                           a = 8'($urandom);
         xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), a, $urandom, rd);
      end

      diffs = 0;
      for (int i = 0; i < 256; i++)
         if (mem[i] !== smem[i]) diffs++;
      check_eq("mem_image", diffs, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
